// File: rtl/clink_tx_framer.sv
// clink_tx_framer -- Camera Link base-configuration transmit framer.
//
// Generates one video frame per accepted trigger: a front porch, h_active x
// v_active pixels with inter-line blanking, then a post-frame blank period.
// Pixel taps carry a test pattern (d0 = column, d1 = line, d2 = d0^d1 or the
// frame counter) and are packed into the 28-bit word a 7:1 serializer expects.
//
// Optional feature macro: CLINK_TX_FRAME_CNT_EN
//   defined   -> d2 carries an 8-bit frame counter that steps on every image_end
//   undefined -> d2 = d0 ^ d1, no frame counter is built
//
// Ports:
//   clk            pixel clock, rising edge
//   rst_n          asynchronous active-low reset
//   trigger        level; starts one frame when sampled high in IDLE
//   h_active       pixels per line
//   v_active       lines per frame
//   h_blank        front-porch / inter-line blank cycles (0 treated as 1)
//   v_blank        post-frame blank cycles (0 treated as 1)
//   clink_tx_word  28-bit serializer word (A/B/C ports + LVAL/FVAL/DVAL)
//   d0, d1, d2     taps A, B, C
//   lval/fval/dval line, frame and data valid
//   busy           frame or its blanking in progress
//   image_end      one-cycle pulse on the first post-frame blank cycle
//   trigger_miss   one-cycle pulse when a trigger arrives while busy

module clink_tx_framer #(
    parameter int CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger,
    input  logic [CNT_WIDTH-1:0] h_active,
    input  logic [CNT_WIDTH-1:0] v_active,
    input  logic [CNT_WIDTH-1:0] h_blank,
    input  logic [CNT_WIDTH-1:0] v_blank,
    output logic [27:0]          clink_tx_word,
    output logic [7:0]           d0,
    output logic [7:0]           d1,
    output logic [7:0]           d2,
    output logic                 lval,
    output logic                 fval,
    output logic                 dval,
    output logic                 busy,
    output logic                 image_end,
    output logic                 trigger_miss
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRONT,
        S_LINE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] h_act_q, v_act_q, h_blk_q, v_blk_q;
    logic [CNT_WIDTH-1:0] x_cnt, y_cnt, blk_cnt;
`ifdef CLINK_TX_FRAME_CNT_EN
    logic [7:0]           frame_cnt;
`endif

    // Last count value of each blank period; a programmed 0 still yields one cycle.
    logic [CNT_WIDTH-1:0] h_blk_last, v_blk_last;

    // Output values decoded from the current state; registered below so every
    // output appears one cycle after the state that produced it.
    logic [7:0] d0_n, d1_n, d2_n;
    logic       lval_n, fval_n, busy_n, image_end_n, miss_n;

    function automatic logic [27:0] map_word(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic lv,
                                             input logic fv, input logic dv);
        logic [27:0] w;
        w        = '0;
        w[4:0]   = a[4:0];
        w[5]     = a[7];
        w[6]     = a[5];
        w[27]    = a[6];
        w[7]     = b[0];
        w[8]     = b[1];
        w[9]     = b[2];
        w[10]    = b[6];
        w[11]    = b[7];
        w[12]    = b[3];
        w[13]    = b[4];
        w[14]    = b[5];
        w[15]    = c[0];
        w[16]    = c[6];
        w[17]    = c[7];
        w[18]    = c[1];
        w[22:19] = c[5:2];
        w[24]    = lv;
        w[25]    = fv;
        w[26]    = dv;
        return w;
    endfunction

    always_comb begin
        // NOTE: every signal gets a value on every path through this block,
        // otherwise synthesis infers a latch to hold the old value.
        h_blk_last  = (h_blk_q == '0) ? '0 : h_blk_q - 1'b1;
        v_blk_last  = (v_blk_q == '0) ? '0 : v_blk_q - 1'b1;
        lval_n      = (state == S_LINE);
        fval_n      = (state == S_FRONT) || (state == S_LINE) || (state == S_HBLANK);
        busy_n      = (state != S_IDLE);
        image_end_n = (state == S_VBLANK) && (blk_cnt == '0);
        miss_n      = busy_n && trigger;
        d0_n        = lval_n ? 8'(x_cnt) : 8'h00;
        d1_n        = lval_n ? 8'(y_cnt) : 8'h00;
`ifdef CLINK_TX_FRAME_CNT_EN
        d2_n        = lval_n ? frame_cnt : 8'h00;
`else
        d2_n        = d0_n ^ d1_n;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, including the latched sizes and counters,
            // is reset so an aborted frame leaves no residue behind.
            state         <= S_IDLE;
            h_act_q       <= '0;
            v_act_q       <= '0;
            h_blk_q       <= '0;
            v_blk_q       <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            blk_cnt       <= '0;
`ifdef CLINK_TX_FRAME_CNT_EN
            frame_cnt     <= '0;
`endif
            clink_tx_word <= '0;
            d0            <= '0;
            d1            <= '0;
            d2            <= '0;
            lval          <= 1'b0;
            fval          <= 1'b0;
            dval          <= 1'b0;
            busy          <= 1'b0;
            image_end     <= 1'b0;
            trigger_miss  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            clink_tx_word <= map_word(d0_n, d1_n, d2_n, lval_n, fval_n, lval_n);
            d0            <= d0_n;
            d1            <= d1_n;
            d2            <= d2_n;
            lval          <= lval_n;
            fval          <= fval_n;
            dval          <= lval_n;
            busy          <= busy_n;
            image_end     <= image_end_n;
            trigger_miss  <= miss_n;
`ifdef CLINK_TX_FRAME_CNT_EN
            if (image_end_n) frame_cnt <= frame_cnt + 8'd1;
`endif

            case (state)
                S_IDLE: begin
                    if (trigger && (h_active != '0) && (v_active != '0)) begin
                        h_act_q <= h_active;
                        v_act_q <= v_active;
                        h_blk_q <= h_blank;
                        v_blk_q <= v_blank;
                        x_cnt   <= '0;
                        y_cnt   <= '0;
                        blk_cnt <= '0;
                        state   <= S_FRONT;
                    end
                end
                S_FRONT: begin
                    if (blk_cnt == h_blk_last) begin
                        blk_cnt <= '0;
                        x_cnt   <= '0;
                        state   <= S_LINE;
                    end else begin
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                end
                S_LINE: begin
                    if (x_cnt == h_act_q - 1'b1) begin
                        blk_cnt <= '0;
                        state   <= (y_cnt == v_act_q - 1'b1) ? S_VBLANK : S_HBLANK;
                    end else begin
                        x_cnt <= x_cnt + 1'b1;
                    end
                end
                S_HBLANK: begin
                    if (blk_cnt == h_blk_last) begin
                        blk_cnt <= '0;
                        x_cnt   <= '0;
                        y_cnt   <= y_cnt + 1'b1;
                        state   <= S_LINE;
                    end else begin
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                end
                S_VBLANK: begin
                    if (blk_cnt == v_blk_last) begin
                        blk_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clink_tx_framer.sv
// Self-checking bench for clink_tx_framer. Each test pushes the expected
// per-cycle outputs of a whole frame into a scoreboard queue (built from the
// frame geometry: porch, lines, blanks) and pops one entry per clock.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_clink_tx_framer;

    localparam int CW = 12;

    typedef struct packed {
        logic [27:0] word;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic        lval;
        logic        fval;
        logic        dval;
        logic        busy;
        logic        image_end;
        logic        trigger_miss;
    } out_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trigger = 1'b0;
    logic [CW-1:0] h_active = '0, v_active = '0, h_blank = '0, v_blank = '0;
    logic [27:0]   clink_tx_word;
    logic [7:0]    d0, d1, d2;
    logic          lval, fval, dval, busy, image_end, trigger_miss;

    int   n_cmp = 0;
    int   n_err = 0;
    int   fcnt  = 0;
    out_t exp_q[$];

    clink_tx_framer #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger),
        .h_active(h_active), .v_active(v_active), .h_blank(h_blank), .v_blank(v_blank),
        .clink_tx_word(clink_tx_word), .d0(d0), .d1(d1), .d2(d2),
        .lval(lval), .fval(fval), .dval(dval), .busy(busy),
        .image_end(image_end), .trigger_miss(trigger_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] map_word(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic l,
                                             input logic f, input logic dv);
        logic [27:0] w;
        w = '0;
        w[4:0] = a[4:0]; w[5] = a[7]; w[6] = a[5]; w[27] = a[6];
        w[7] = b[0]; w[8] = b[1]; w[9] = b[2]; w[10] = b[6];
        w[11] = b[7]; w[12] = b[3]; w[13] = b[4]; w[14] = b[5];
        w[15] = c[0]; w[16] = c[6]; w[17] = c[7]; w[18] = c[1]; w[22:19] = c[5:2];
        w[24] = l; w[25] = f; w[26] = dv;
        return w;
    endfunction

    function automatic out_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic l, input logic f, input logic dv,
                                input logic bz, input logic ie, input logic ms);
        out_t r;
        r.word = map_word(a, b, c, l, f, dv);
        r.d0 = a; r.d1 = b; r.d2 = c;
        r.lval = l; r.fval = f; r.dval = dv;
        r.busy = bz; r.image_end = ie; r.trigger_miss = ms;
        return r;
    endfunction

    function automatic out_t obs();
        out_t r;
        r.word = clink_tx_word;
        r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.lval = lval; r.fval = fval; r.dval = dval;
        r.busy = busy; r.image_end = image_end; r.trigger_miss = trigger_miss;
        return r;
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('0);
    endtask

    // Expected output sequence of one frame, starting with the first porch cycle.
    task automatic push_frame(input int h, input int v, input int hb, input int vb, input logic ms);
        int hbe = (hb == 0) ? 1 : hb;
        int vbe = (vb == 0) ? 1 : vb;
        logic [7:0] px, py, pc;
        for (int i = 0; i < hbe; i++) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, ms));
        for (int y = 0; y < v; y++) begin
            if (y > 0)
                for (int i = 0; i < hbe; i++) exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, ms));
            for (int x = 0; x < h; x++) begin
                px = 8'(x);
                py = 8'(y);
`ifdef CLINK_TX_FRAME_CNT_EN
                pc = 8'(fcnt);
`else
                pc = px ^ py;
`endif
                exp_q.push_back(mk(px, py, pc, 1, 1, 1, 1, 0, ms));
            end
        end
        for (int i = 0; i < vbe; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, i == 0, ms));
        fcnt = (fcnt + 1) % 256;
    endtask

    task automatic set_sizes(input int h, input int v, input int hb, input int vb);
        h_active = CW'(h); v_active = CW'(v); h_blank = CW'(hb); v_blank = CW'(vb);
    endtask

    task automatic test_reset();
        out_t e, o;
        repeat (2) @(negedge clk);
        o = obs();
        n_cmp++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h required 0", o);
        end
        rst_n = 1'b1;
        fcnt  = 0;
        push_idle(3);
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL post_reset_idle[%0d]: got %h required %h", idx, o, e);
            end
        end
    endtask

    task automatic test_spot_check();
        out_t e, o;
        logic [27:0] spot;
`ifdef CLINK_TX_FRAME_CNT_EN
        spot = 28'h700_0020;
`else
        spot = 28'h702_0020;
`endif
        @(negedge clk);
        set_sizes(130, 1, 1, 1);
        trigger = 1'b1;
        push_idle(1);
        push_frame(130, 1, 1, 1, 1'b0);
        push_idle(1);
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            @(negedge clk);
            trigger = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL spot_frame[%0d]: got %h required %h", idx, o, e);
            end
            if (idx == 130) begin
                n_cmp++;
                if (clink_tx_word !== spot || d0 !== 8'h80) begin
                    n_err++;
                    $display("FAIL spot_word: got %h d0=%h required %h d0=80", clink_tx_word, d0, spot);
                end
            end
        end
    endtask

    task automatic test_basic();
        out_t e, o;
        int fval_rise = -1, ie_at = -1, fval_cycles = 0, lval_cycles = 0;
        @(negedge clk);
        set_sizes(4, 2, 2, 3);
        trigger = 1'b1;
        push_idle(1);
        push_frame(4, 2, 2, 3, 1'b0);
        push_idle(2);
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            @(negedge clk);
            trigger = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL basic[%0d]: got %h required %h", idx, o, e);
            end
            if (o.fval === 1'b1) begin
                fval_cycles++;
                if (fval_rise < 0) fval_rise = idx;
            end
            if (o.lval === 1'b1) lval_cycles++;
            if (o.image_end === 1'b1) ie_at = idx;
        end
        n_cmp++;
        if (fval_cycles != 12 || lval_cycles != 8 || fval_rise != 1 || ie_at - fval_rise != 12) begin
            n_err++;
            $display("FAIL basic_timing: fval=%0d lval=%0d rise=%0d ie_delta=%0d required 12 8 1 12",
                     fval_cycles, lval_cycles, fval_rise, ie_at - fval_rise);
        end
    endtask

    task automatic test_zero_size();
        out_t o;
        @(negedge clk);
        set_sizes(0, 3, 1, 1);
        trigger = 1'b1;
        for (int idx = 0; idx < 12; idx++) begin
            @(negedge clk);
            if (idx == 6) set_sizes(3, 0, 1, 1);
            o = obs();
            n_cmp++;
            if (o !== '0) begin
                n_err++;
                $display("FAIL zero_size[%0d]: got %h required 0", idx, o);
            end
        end
        trigger = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_blank_zero();
        out_t e, o;
        @(negedge clk);
        set_sizes(2, 2, 0, 0);
        trigger = 1'b1;
        push_idle(1);
        push_frame(2, 2, 0, 0, 1'b0);
        push_idle(2);
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            @(negedge clk);
            trigger = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL blank_zero[%0d]: got %h required %h", idx, o, e);
            end
        end
    endtask

    task automatic test_trigger_miss();
        out_t e, o;
        @(negedge clk);
        set_sizes(2, 1, 1, 1);
        trigger = 1'b1;
        push_idle(1);
        push_frame(2, 1, 1, 1, 1'b1);
        push_idle(1);
        push_frame(2, 1, 1, 1, 1'b1);
        push_idle(2);
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL trigger_miss[%0d]: got %h required %h", idx, o, e);
            end
            if (idx == 9) trigger = 1'b0;
        end
    endtask

    task automatic test_size_change();
        out_t e, o;
        @(negedge clk);
        set_sizes(3, 2, 1, 1);
        trigger = 1'b1;
        push_idle(1);
        push_frame(3, 2, 1, 1, 1'b0);
        push_idle(2);
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            @(negedge clk);
            trigger = 1'b0;
            set_sizes(7, 5, 4, 4);
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL size_change[%0d]: got %h required %h", idx, o, e);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        out_t e, o;
        @(negedge clk);
        set_sizes(4, 2, 2, 3);
        trigger = 1'b1;
        push_idle(1);
        push_frame(4, 2, 2, 3, 1'b0);
        for (int idx = 0; idx < 5; idx++) begin
            @(negedge clk);
            trigger = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pre_abort[%0d]: got %h required %h", idx, o, e);
            end
        end
        exp_q.delete();
        rst_n = 1'b0;
        fcnt  = 0;
        #1;
        o = obs();
        n_cmp++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL abort_async: got %h required 0", o);
        end
        @(negedge clk);
        o = obs();
        n_cmp++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL abort_next_cycle: got %h required 0", o);
        end
        rst_n = 1'b1;
        push_idle(6);
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL after_abort[%0d]: got %h required %h", idx, o, e);
            end
        end
    endtask

`ifdef CLINK_TX_FRAME_CNT_EN
    task automatic test_frame_wrap();
        out_t e, o;
        @(negedge clk);
        set_sizes(1, 1, 0, 0);
        trigger = 1'b1;
        push_idle(1);
        for (int f = 0; f < 257; f++) begin
            push_frame(1, 1, 0, 0, 1'b1);
            push_idle(1);
        end
        push_idle(1);
        for (int idx = 0; exp_q.size() > 0; idx++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL frame_wrap[%0d]: got %h required %h", idx, o, e);
            end
            if (idx == 1022 || idx == 1026) begin
                n_cmp++;
                if (lval !== 1'b1 || d2 !== ((idx == 1022) ? 8'hFF : 8'h00)) begin
                    n_err++;
                    $display("FAIL frame_wrap_d2[%0d]: got lval=%b d2=%h", idx, lval, d2);
                end
            end
            if (idx == 1027) trigger = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_spot_check();
        test_basic();
        test_zero_size();
        test_blank_zero();
        test_trigger_miss();
        test_size_change();
        test_mid_frame_reset();
`ifdef CLINK_TX_FRAME_CNT_EN
        test_frame_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clink_tx_framer.md
CLINK_TX_FRAMER -- requirements
Module: clink_tx_framer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 12: width of all size inputs and internal x/y/blank counters.
REQ-002 SHALL have port clk  input  1  pixel clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port trigger  input  1  level, sampled each cycle; starts one frame.
REQ-005 SHALL have ports h_active, v_active, h_blank, v_blank  input  CNT_WIDTH each  pixels/line, lines/frame, inter-line blank cycles, post-frame blank cycles.
REQ-006 SHALL have port clink_tx_word  output  28  Camera Link standard-order word for a 7:1 serializer.
REQ-007 SHALL have ports d0, d1, d2  output  8 each  taps A, B, C.
REQ-008 SHALL have ports lval, fval, dval  output  1 each  line, frame and data valid.
REQ-009 SHALL have port busy  output  1  high while a frame or its blanking is in progress.
REQ-010 SHALL have ports image_end, trigger_miss  output  1 each  single-cycle pulses.

Function
REQ-011 SHALL implement FSM IDLE, FRONT, LINE, HBLANK, VBLANK; all outputs registered.
REQ-012 In IDLE, a sampled trigger=1 with h_active!=0 and v_active!=0 SHALL latch all four size inputs and enter FRONT next cycle; if either active size is 0, trigger SHALL be ignored.
REQ-013 FRONT SHALL last max(h_blank,1) cycles with fval=1, lval=0, dval=0, then enter LINE.
REQ-014 LINE SHALL last h_active cycles with fval=lval=dval=1; x counts 0..h_active-1 and y holds the current line index.
REQ-015 Transitions at end of LINE: y<v_active-1 -> HBLANK; y==v_active-1 -> VBLANK.
REQ-016 HBLANK SHALL last max(h_blank,1) cycles with fval=1, lval=dval=0; y SHALL increment, then enter LINE.
REQ-017 VBLANK SHALL last max(v_blank,1) cycles with fval=lval=dval=0, then enter IDLE.
REQ-018 image_end SHALL pulse for exactly the first VBLANK cycle, which is the cycle in which fval first reads 0.
REQ-019 Latency: trigger sampled at edge k SHALL produce fval=1 at the outputs after edge k+1.
REQ-020 busy SHALL be 1 in FRONT, LINE, HBLANK and VBLANK, and 0 in IDLE.
REQ-021 trigger=1 sampled while busy=1 SHALL be ignored and SHALL pulse trigger_miss for 1 cycle.
REQ-022 Pixel data during LINE: d0=x[7:0], d1=y[7:0], d2 per REQ-030/031; outside LINE, d0=d1=d2=0.
REQ-023 Size input changes mid-frame SHALL have no effect until the next accepted trigger.
REQ-024 An 8-bit frame counter SHALL increment on each image_end and wrap 255->0.
REQ-025 clink_tx_word mapping, A-port bits:
- [4:0]=d0[4:0], [5]=d0[7], [6]=d0[5], [27]=d0[6].
REQ-026 clink_tx_word mapping, B-port bits:
- [7]=d1[0], [8]=d1[1], [9]=d1[2], [10]=d1[6], [11]=d1[7], [12]=d1[3], [13]=d1[4], [14]=d1[5].
REQ-027 clink_tx_word mapping, C-port bits:
- [15]=d2[0], [16]=d2[6], [17]=d2[7], [18]=d2[1], [22:19]=d2[5:2].
REQ-028 clink_tx_word mapping, control and spare bits:
- [23]=0, [24]=lval, [25]=fval, [26]=dval.

Reset
REQ-029 While rst_n=0, the block SHALL be in IDLE, all counters and the frame counter SHALL be 0, and every output SHALL be 0; reset asserted mid-frame SHALL abort the frame immediately, with no image_end pulse.

Configuration
REQ-030 With macro CLINK_TX_FRAME_CNT_EN defined, d2 during LINE SHALL equal the frame counter value.
REQ-031 Without CLINK_TX_FRAME_CNT_EN, d2 during LINE SHALL equal d0 XOR d1, and the frame counter logic SHALL be absent.

Verification
REQ-032 Sizes h_active=4, v_active=2, h_blank=2, v_blank=3; one trigger -> fval high for 2+4+2+4=12 cycles, lval high in two 4-cycle runs with d0=0,1,2,3 and d1=0 then 1; image_end pulses once, 12 cycles after fval rises.
REQ-033 trigger held high through a frame (h_active=2, v_active=1, h_blank=1, v_blank=1) -> trigger_miss pulses every busy cycle, and a new frame starts the cycle after VBLANK ends.
REQ-034 h_active=0 with trigger=1 -> busy stays 0 and all outputs stay 0.
REQ-035 h_blank=0 and v_blank=0 -> each blank period lasts exactly 1 cycle.
REQ-036 rst_n dropped during LINE -> next-cycle outputs all 0 and no image_end; with CLINK_TX_FRAME_CNT_EN, 256 consecutive frames -> d2 returns to 0.
REQ-037 Spot-check mapping: d0=8'h80, d1=0, d2=0 in LINE -> clink_tx_word=28'h700_0020 (bits 5, 24, 25, 26).
